rr_seg_arbiter: RTL

- Round-robin arbiter that shares one active-low 7-segment digit among 8 requesters.
- Grants one requester at a time for a bounded hold window.
- Reports the granted index on y/z, priority-encoder style.
- Drives the digit with the granted index + 1 (1..8). Shows "0" when idle and blanks when disabled.

---
 rtl/rr_seg_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rr_seg_arbiter.sv
// Round-robin arbiter: 8 requesters share one active-low 7-segment digit showing grantee index + 1.
// Latency: req to gnt exactly 1 cycle; all outputs registered; back-to-back grants on release.
// Backpressure: none; a grant lasts at most HOLD_CYCLES cycles. Define FIXED_PRIO_EN for fixed priority (7 highest).
module rr_seg_arbiter #(
  parameter int HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic [7:0] req,
  input  logic       rel,
  output logic [7:0] gnt,
  output logic [2:0] y,
  output logic       z,
  output logic       A,
  output logic       B,
  output logic       C,
  output logic       D,
  output logic       E,
  output logic       F,
  output logic       G
);

  typedef enum logic {IDLE, GRANT} state_t;

  localparam logic [7:0] RELOAD = 8'(HOLD_CYCLES - 1);
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  state_t     state_q, state_d;
  logic [2:0] last_q, last_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] gnt_q, gnt_d;
  logic [2:0] y_q, y_d;
  logic       z_q, z_d;
  logic [6:0] seg_q, seg_d;

  logic [3:0] pick_idle;
  logic [3:0] pick_rel;
  logic       release_now;

  // Winner search: returns {found, index}. Round-robin starts just after base.
  function automatic logic [3:0] pick(input logic [7:0] r, input logic [2:0] base);
    logic [3:0] res;
    logic [2:0] idx;
    res = 4'b0000;
    idx = 3'd0;
`ifdef FIXED_PRIO_EN
    // Highest set index wins; base is irrelevant.
    for (int i = 0; i < 8; i++) begin
      idx = 3'(i);
      if (r[idx] && (base == base)) res = {1'b1, idx};
    end
`else
    // Scan from farthest to nearest so the nearest candidate after base wins.
    for (int k = 8; k >= 1; k--) begin
      idx = base + 3'(k);
      if (r[idx]) res = {1'b1, idx};
    end
`endif
    return res;
  endfunction

  // Active-low {A..G} pattern for digits 0..8.
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b1100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // Candidate winners for a fresh search from idle and for a search after a release.
  always_comb begin
    pick_idle   = pick(req, last_q);
    pick_rel    = pick(req, y_q);
    release_now = (cnt_q == 8'd0) || rel || !req[y_q];
  end

  // Next-state and registered-output computation.
  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    y_d     = y_q;
    z_d     = z_q;
    seg_d   = seg_q;

    if (!en) begin
      // Disable wins over everything; the pointer is kept.
      state_d = IDLE;
      cnt_d   = 8'd0;
      gnt_d   = 8'd0;
      y_d     = 3'd0;
      z_d     = 1'b0;
      seg_d   = SEG_BLANK;
    end else begin
      case (state_q)
        IDLE: begin
          if (pick_idle[3]) begin
            state_d = GRANT;
            cnt_d   = RELOAD;
            gnt_d   = 8'd1 << pick_idle[2:0];
            y_d     = pick_idle[2:0];
            z_d     = 1'b1;
            seg_d   = seg_of({1'b0, pick_idle[2:0]} + 4'd1);
          end else begin
            cnt_d = 8'd0;
            gnt_d = 8'd0;
            y_d   = 3'd0;
            z_d   = 1'b0;
            seg_d = seg_of(4'd0);
          end
        end
        GRANT: begin
          if (release_now) begin
            last_d = y_q;
            if (pick_rel[3]) begin
              // Back-to-back hand-over (possibly to the same requester).
              state_d = GRANT;
              cnt_d   = RELOAD;
              gnt_d   = 8'd1 << pick_rel[2:0];
              y_d     = pick_rel[2:0];
              z_d     = 1'b1;
              seg_d   = seg_of({1'b0, pick_rel[2:0]} + 4'd1);
            end else begin
              state_d = IDLE;
              cnt_d   = 8'd0;
              gnt_d   = 8'd0;
              y_d     = 3'd0;
              z_d     = 1'b0;
              seg_d   = seg_of(4'd0);
            end
          end else begin
            cnt_d = cnt_q - 8'd1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      last_q  <= 3'd7;
      cnt_q   <= 8'd0;
      gnt_q   <= 8'd0;
      y_q     <= 3'd0;
      z_q     <= 1'b0;
      seg_q   <= SEG_BLANK;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      y_q     <= y_d;
      z_q     <= z_d;
      seg_q   <= seg_d;
    end
  end

  assign gnt = gnt_q;
  assign y   = y_q;
  assign z   = z_q;
  assign {A, B, C, D, E, F, G} = seg_q;

endmodule
